// File: rtl/mult_pkg.sv
// Shared constants, Booth digit encoding and carry-save tree sizing helpers
// for the signed multiplier.
package mult_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int PP_COUNT   = DEF_WIDTH / 2;
    localparam int PROD_WIDTH = 2 * DEF_WIDTH;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_op_e;

    // Window is {b[2i+1], b[2i], b[2i-1]}; digit = -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic booth_op_e booth_decode(input logic [2:0] window);
        booth_op_e op;
        case (window)
            3'b001, 3'b010: op = BOOTH_POS1;
            3'b011:         op = BOOTH_POS2;
            3'b100:         op = BOOTH_NEG2;
            3'b101, 3'b110: op = BOOTH_NEG1;
            default:        op = BOOTH_ZERO;
        endcase
        return op;
    endfunction

    function automatic int csa_next(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int csa_count(input int n, input int level);
        int c;
        c = n;
        for (int l = 0; l < level; l++) c = csa_next(c);
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = csa_next(c);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/mult_booth_pp.sv
// One radix-4 Booth partial product: digit * multiplicand, sign-extended to
// the full product width (shift by window position is applied by the caller).
module mult_booth_pp
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]         window,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] pp
);

    booth_op_e          op;
    logic [2*WIDTH-1:0] ext;

    always_comb begin
        op  = booth_decode(window);
        ext = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
        pp  = '0;
        case (op)
            BOOTH_POS1: pp = ext;
            BOOTH_POS2: pp = ext << 1;
            BOOTH_NEG1: pp = -ext;
            BOOTH_NEG2: pp = -(ext << 1);
            default:    pp = '0;
        endcase
    end

endmodule

// File: rtl/mult.sv
// Two-stage signed multiplier: operand registers, then Booth partial products
// reduced by a 3:2 carry-save tree and one carry-propagate add into z.
module mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] z
);

    localparam int NPP  = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int NLEV = csa_levels(NPP);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   b_ext;
    logic [PW-1:0]    pp  [NPP];
    logic [PW-1:0]    lvl [NLEV+1][NPP];
    logic [PW-1:0]    sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            z   <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
            z   <= sum;
        end
    end

    // Implicit b[-1] = 0 below the LSB for the first Booth window.
    assign b_ext = {b_q, 1'b0};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        mult_booth_pp #(.WIDTH(WIDTH)) u_pp (
            .window      (b_ext[2*i+2 -: 3]),
            .multiplicand(a_q),
            .pp          (pp[i])
        );
        assign lvl[0][i] = pp[i] << (2 * i);
    end

    // Each level compresses groups of three rows into sum/carry; leftovers pass through.
    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        localparam int N = csa_count(NPP, l);
        localparam int G = N / 3;
        localparam int R = N % 3;
        localparam int M = 2 * G + R;
        for (genvar g = 0; g < G; g++) begin : g_csa
            assign lvl[l+1][2*g]   = lvl[l][3*g] ^ lvl[l][3*g+1] ^ lvl[l][3*g+2];
            assign lvl[l+1][2*g+1] = ((lvl[l][3*g] & lvl[l][3*g+1]) |
                                      (lvl[l][3*g] & lvl[l][3*g+2]) |
                                      (lvl[l][3*g+1] & lvl[l][3*g+2])) << 1;
        end
        for (genvar r = 0; r < R; r++) begin : g_pass
            assign lvl[l+1][2*G+r] = lvl[l][3*G+r];
        end
        for (genvar u = M; u < NPP; u++) begin : g_zero
            assign lvl[l+1][u] = '0;
        end
    end

    assign sum = lvl[NLEV][0] + lvl[NLEV][1];

endmodule

// File: tb/tb_mult.sv
// Bench for mult: directed corner products, 1000 back-to-back random pairs,
// and asynchronous reset behaviour, checked against an arithmetic model.
module tb_mult;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] z;

    logic [2*W-1:0] exp_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;

    mult #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .z    (z)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
        return p;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7FFF_FFFF;
            2:       v = 32'hFFFF_FFFF;
            3:       v = '0;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] expv);
        n_cmp++;
        assert (z === expv)
        else begin
            n_bad++;
            $error("FAIL %s: z=%h expected=%h", tag, z, expv);
        end
    endtask

    // Check the product due this cycle, then present the next operand pair.
    task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] e);
        @(negedge clk);
        check(tag, exp_q.pop_front());
        a = x;
        b = y;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset asserted between edges clears everything at once.
        #2 reset = 1'b0;
        #1 check("reset_async_initial", '0);
        repeat (2) @(negedge clk);
        check("reset_held", '0);
        reset = 1'b1;
        a = '0;
        b = '0;
        exp_q = {64'd0, 64'd0};

        step("pre_3x2_a", 32'd3, 32'd2, 64'd6);
        step("pre_3x2_b", 32'd3, 32'd2, 64'd6);
        step("3x2_first", 32'd5, 32'h8000_0000, 64'hFFFF_FFFD_8000_0000);
        step("3x2_second", 32'hFFFF_FFFB, 32'h8000_0000, 64'h0000_0002_8000_0000);
        step("5xmin", 32'd0, 32'h8000_0000, 64'd0);
        step("m5xmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        step("0xmin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        step("minxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        step("m1xm1", 32'hFFFF_FFF9, 32'd0, 64'd0);
        step("maxxmin", 32'hDEAD_BEEF, 32'hDEAD_BEEF, ref_prod(32'hDEAD_BEEF, 32'hDEAD_BEEF));
        step("neg_x0", 32'hDEAD_BEEF, 32'hDEAD_BEEF, ref_prod(32'hDEAD_BEEF, 32'hDEAD_BEEF));
        // Constant operands keep producing the same product.
        step("hold_a", 32'hDEAD_BEEF, 32'hDEAD_BEEF, ref_prod(32'hDEAD_BEEF, 32'hDEAD_BEEF));
        step("hold_b", 32'hDEAD_BEEF, 32'hDEAD_BEEF, ref_prod(32'hDEAD_BEEF, 32'hDEAD_BEEF));

        for (int i = 0; i < 1000; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            step("random", ra, rb, ref_prod(ra, rb));
        end
        ra = 32'h1234_5679;
        rb = 32'h8765_4321;
        step("pre_reset_a", ra, rb, ref_prod(ra, rb));
        step("pre_reset_b", ra, rb, ref_prod(ra, rb));
        @(negedge clk);
        check("pre_reset_nonzero", exp_q.pop_front());

        // Mid-cycle reset: z must drop before the next clock edge.
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("reset_async_midstream", '0);
        @(negedge clk);
        check("reset_midstream_held", '0);
        ra = $urandom | 32'h1;
        rb = $urandom | 32'h3;
        reset = 1'b1;
        a = ra;
        b = rb;
        exp_q = {64'd0};
        exp_q.push_back(ref_prod(ra, rb));
        for (int i = 0; i < 20; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            step("after_reset", ra, rb, ref_prod(ra, rb));
        end
        step("drain_a", '0, '0, 64'd0);
        step("drain_b", '0, '0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult.md
MULT -- requirements
Module: mult

Interface
REQ-001 Parameter WIDTH, default 32, operand width; z is 2*WIDTH bits; only 32 is verified.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted, 1 = run).
REQ-004 a  input  WIDTH  multiplicand, two's-complement signed.
REQ-005 b  input  WIDTH  multiplier, two's-complement signed.
REQ-006 z  output  2*WIDTH  signed product a*b, registered.

Function
REQ-007 mult SHALL compute the full-precision signed product z = a*b with no truncation, rounding or saturation.
REQ-008 Pipeline stage 1 SHALL register a and b on each rising clk edge while reset=1.
REQ-009 Stage 2 SHALL form radix-4 Booth partial products from the stage-1 registers (16 PPs for WIDTH=32), sum them with sign extension to 2*WIDTH bits, and register the sum into z.
REQ-010 Latency SHALL be exactly 2 rising edges: operands sampled at edge N appear on z after edge N+1.
REQ-011 Throughput SHALL be one new operand pair per cycle; there is no handshake, valid or stall.
REQ-012 Operands held constant SHALL produce a constant z from the second edge onward.
REQ-013 Corner operand -2^(WIDTH-1) SHALL be handled exactly; (-2^31)*(-2^31) = +2^62, no overflow.
REQ-014 Multiplication by 0 SHALL yield z = 0 regardless of the other operand's sign.
REQ-015 z SHALL depend only on registered state; no combinational path from a or b to z.

Reset
REQ-016 While reset=0, stage-1 operand registers and z SHALL be cleared to 0 immediately, without waiting for clk.
REQ-017 Reset assertion mid-stream SHALL discard in-flight products; after release, z SHALL stay 0 until the first operands sampled after release complete their 2-edge latency.
REQ-018 Release of reset SHALL be treated as synchronous to clk by the surrounding logic; no internal synchronizer.

Structure
REQ-019 A shared package SHALL hold WIDTH default, PP count (WIDTH/2), product width and the Booth digit encoding constants.
REQ-020 One sub-module, mult_booth_pp, SHALL generate a single sign-extended partial product from a 3-bit Booth window and the multiplicand; mult instantiates it WIDTH/2 times.
REQ-021 The partial-product adder SHALL be a carry-save (Wallace/Dadda or 3:2 compressor) tree followed by one final carry-propagate adder.

Verification
REQ-022 Reset low, then high; a=3, b=2 held 2 cycles -> z = 6 (0x0000000000000006) after 2 edges.
REQ-023 a=5, b=0x80000000 -> z = 0xFFFFFFFD80000000 (-10737418240).
REQ-024 a=-5, b=0x80000000 -> z = 0x0000000280000000 (+10737418240); a=0, same b -> z = 0.
REQ-025 a=b=0x80000000 -> z = 0x4000000000000000; a=b=0xFFFFFFFF -> z = 1; a=0x7FFFFFFF, b=0x80000000 -> z = 0xC000000080000000.
REQ-026 Back-to-back: a new operand pair every cycle for 1000 random signed vectors -> each z equals the reference product exactly 2 edges later.
REQ-027 Reset pulled low between clock edges with nonzero z -> z = 0 immediately (before next edge), remains 0 until 2 edges after release with new operands.
